// File: rtl/bdd_pkg.sv
// Shared types and word layouts for the decision-tree traversal sequencer.
package bdd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_MAC0,
    S_MAC1,
    S_MAC2,
    S_DECIDE,
    S_FIN
  } state_t;

  localparam int NODE_C1_LSB  = 24;
  localparam int NODE_C2_LSB  = 16;
  localparam int NODE_C3_LSB  = 8;
  localparam int NODE_THR_LSB = 0;

  localparam int CHILD_FIELD_W = 9;
  localparam int CHILD_HI_LSB  = 9;
  localparam int CHILD_LO_LSB  = 0;

  localparam int FEAT_F0_LSB = 16;
  localparam int FEAT_F1_LSB = 8;
  localparam int FEAT_F2_LSB = 0;

  localparam int         LEAF_BIT  = 8;
  localparam logic [7:0] ERR_CLASS = 8'hFF;

  function automatic logic [7:0] byte_at(input logic [31:0] w, input int lsb);
    return w[lsb +: 8];
  endfunction

  function automatic logic [CHILD_FIELD_W-1:0] child_field(input logic [17:0] w,
                                                           input logic take_hi);
    return take_hi ? w[CHILD_HI_LSB +: CHILD_FIELD_W] : w[CHILD_LO_LSB +: CHILD_FIELD_W];
  endfunction

endpackage

// File: rtl/bdd_traverse_ctrl_depth_guard.sv
// Node-visit counter; last flags the visit whose successor would exceed MAX_DEPTH.
module bdd_depth_guard #(
  parameter int MAX_DEPTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam int CNT_W = $clog2(MAX_DEPTH + 1);

  logic [CNT_W-1:0] depth;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth <= '0;
    end else if (clr) begin
      depth <= '0;
    end else if (inc) begin
      depth <= depth + 1'b1;
    end
  end

  assign last = (depth == CNT_W'(MAX_DEPTH - 1));

endmodule

// File: rtl/bdd_traverse_ctrl.sv
// Tree-walk sequencer: fetch node, three-term MAC, threshold compare, follow child.
module bdd_traverse_ctrl
  import bdd_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int ACC_W     = 18,
  parameter int MAX_DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] root_addr,
  input  logic [23:0]       feature,
  output logic              busy,
  output logic              done,
  output logic [7:0]        class_o,
  output logic              err,
  output logic [ADDR_W-1:0] node_addr,
  output logic              sram_re,
  input  logic [31:0]       node_data,
  input  logic [17:0]       child_data,
  output logic              mac_clr,
  output logic              mac_en,
  output logic [7:0]        mac_a,
  output logic [7:0]        mac_b,
  input  logic [ACC_W-1:0]  mac_acc
);

  state_t state;

  // c1 goes straight from node_data to mac_a, so only {c2,c3,thr} are kept.
  logic [23:0] coef_r;
  logic [17:0] child_r;
  logic [23:0] feat_r;

  logic                     take_hi;
  logic [CHILD_FIELD_W-1:0] sel;
  logic                     accept;
  logic                     depth_inc;
  logic                     depth_last;

  assign accept    = (state == S_IDLE) && start;
  assign take_hi   = mac_acc < ACC_W'(byte_at({8'h00, coef_r}, NODE_THR_LSB));
  assign sel       = child_field(child_r, take_hi);
  assign depth_inc = (state == S_DECIDE) && !sel[LEAF_BIT] && !depth_last;

  bdd_depth_guard #(
    .MAX_DEPTH(MAX_DEPTH)
  ) u_depth_guard (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept),
    .inc  (depth_inc),
    .last (depth_last)
  );

  // Datapath captures: no reset needed, always written before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      feat_r <= feature;
    end
    if (state == S_WAIT) begin
      coef_r  <= node_data[23:0];
      child_r <= child_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      class_o   <= 8'h00;
      node_addr <= '0;
      sram_re   <= 1'b0;
      mac_clr   <= 1'b0;
      mac_en    <= 1'b0;
      mac_a     <= 8'h00;
      mac_b     <= 8'h00;
    end else begin
      sram_re <= 1'b0;
      mac_clr <= 1'b0;
      mac_en  <= 1'b0;
      mac_a   <= 8'h00;
      mac_b   <= 8'h00;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_FETCH;
            busy      <= 1'b1;
            err       <= 1'b0;
            class_o   <= 8'h00;
            node_addr <= root_addr;
            sram_re   <= 1'b1;
          end
        end
        S_FETCH: begin
          state   <= S_WAIT;
          mac_clr <= 1'b1;
        end
        S_WAIT: begin
          state  <= S_MAC0;
          mac_en <= 1'b1;
          mac_a  <= byte_at(node_data, NODE_C1_LSB);
          mac_b  <= byte_at({8'h00, feat_r}, FEAT_F0_LSB);
        end
        S_MAC0: begin
          state  <= S_MAC1;
          mac_en <= 1'b1;
          mac_a  <= byte_at({8'h00, coef_r}, NODE_C2_LSB);
          mac_b  <= byte_at({8'h00, feat_r}, FEAT_F1_LSB);
        end
        S_MAC1: begin
          state  <= S_MAC2;
          mac_en <= 1'b1;
          mac_a  <= byte_at({8'h00, coef_r}, NODE_C3_LSB);
          mac_b  <= byte_at({8'h00, feat_r}, FEAT_F2_LSB);
        end
        S_MAC2: begin
          state <= S_DECIDE;
        end
        S_DECIDE: begin
          if (sel[LEAF_BIT]) begin
            state   <= S_FIN;
            class_o <= sel[7:0];
            err     <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else if (depth_last) begin
            state   <= S_FIN;
            class_o <= ERR_CLASS;
            err     <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            state     <= S_FETCH;
            node_addr <= ADDR_W'(sel[7:0]);
            sram_re   <= 1'b1;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bdd_traverse_ctrl.sv
// Directed bench for bdd_traverse_ctrl with behavioural node/child SRAMs and MAC.
module tb_bdd_traverse_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  root_addr;
  logic [23:0] feature;
  logic        busy;
  logic        done;
  logic [7:0]  class_o;
  logic        err;
  logic [7:0]  node_addr;
  logic        sram_re;
  logic [31:0] node_data;
  logic [17:0] child_data;
  logic        mac_clr;
  logic        mac_en;
  logic [7:0]  mac_a;
  logic [7:0]  mac_b;
  logic [17:0] mac_acc;

  logic [31:0] node_mem  [256];
  logic [17:0] child_mem [256];

  int checks = 0;
  int errors = 0;
  int acc_wait;

  bdd_traverse_ctrl #(
    .ADDR_W   (8),
    .ACC_W    (18),
    .MAX_DEPTH(32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .root_addr (root_addr),
    .feature   (feature),
    .busy      (busy),
    .done      (done),
    .class_o   (class_o),
    .err       (err),
    .node_addr (node_addr),
    .sram_re   (sram_re),
    .node_data (node_data),
    .child_data(child_data),
    .mac_clr   (mac_clr),
    .mac_en    (mac_en),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_acc   (mac_acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_re) begin
      node_data  <= node_mem[node_addr];
      child_data <= child_mem[node_addr];
    end
    if (mac_clr) mac_acc <= 18'd0;
    else if (mac_en) mac_acc <= mac_acc + 18'(mac_a * mac_b);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge where done is high.
  task automatic run_walk(input string tag, input logic [7:0] root, input logic [23:0] feat,
                          input logic [7:0] exp_class, input logic exp_err,
                          input int exp_cyc, input int poke, output int waited);
    int cyc;
    bit seen;
    start     = 1'b1;
    root_addr = root;
    feature   = feat;
    waited    = 0;
    while (busy !== 1'b1 && waited < 4) begin
      step();
      waited++;
    end
    start = 1'b0;
    chk({tag, "_accept"}, busy, 1'b1);
    cyc  = 1;
    seen = 0;
    while (!seen && cyc < 400) begin
      if (cyc == poke) begin
        start     = 1'b1;
        root_addr = 8'h00;
        feature   = 24'h020202;
      end else if (cyc == poke + 1) begin
        start = 1'b0;
      end
      if (done === 1'b1) seen = 1;
      else begin
        step();
        cyc++;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_cycles"}, cyc, exp_cyc);
    chk({tag, "_class"}, class_o, exp_class);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_busy_at_done"}, busy, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      node_mem[i]  = 32'h0;
      child_mem[i] = 18'h0;
    end
    node_mem[8'h00] = 32'h01010110; child_mem[8'h00] = 18'h20A00; // hi=105
    node_mem[8'h10] = 32'h02000004; child_mem[8'h10] = 18'h3DC03; // hi=1EE lo=003
    node_mem[8'h03] = 32'h00000000; child_mem[8'h03] = 18'h2AB2A; // hi=155 lo=12A
    node_mem[8'h20] = 32'h04040020; child_mem[8'h20] = 18'h22322; // hi=111 lo=122
    node_mem[8'h21] = 32'h04040021; child_mem[8'h21] = 18'h22322;
    node_mem[8'h30] = 32'h00000000; child_mem[8'h30] = 18'h06030; // self loop
    node_mem[8'h40] = 32'hFFFFFFFF; child_mem[8'h40] = 18'h31177; // hi=188 lo=177
    node_data  = 32'h0;
    child_data = 18'h0;
    mac_acc    = 18'h0;

    rst_n     = 1'b0;
    start     = 1'b0;
    root_addr = 8'h00;
    feature   = 24'h0;
    step();
    step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_class", class_o, 8'h00);
    chk("rst_sram_re", sram_re, 1'b0);
    chk("rst_mac_en", mac_en, 1'b0);
    rst_n = 1'b1;
    step();

    run_walk("leaf", 8'h00, 24'h020202, 8'h05, 1'b0, 7, 0, acc_wait);
    step();
    chk("leaf_done_pulse", done, 1'b0);
    run_walk("two_level", 8'h10, 24'h030000, 8'h2A, 1'b0, 13, 0, acc_wait);
    step();
    run_walk("equal", 8'h20, 24'h040400, 8'h22, 1'b0, 7, 0, acc_wait);
    step();
    run_walk("less", 8'h21, 24'h040400, 8'h11, 1'b0, 7, 0, acc_wait);
    step();
    run_walk("max_operands", 8'h40, 24'hFFFFFF, 8'h77, 1'b0, 7, 0, acc_wait);
    step();
    run_walk("loop", 8'h30, 24'h010203, 8'hFF, 1'b1, 193, 0, acc_wait);
    step();
    chk("loop_done_pulse", done, 1'b0);
    chk("loop_err_held", err, 1'b1);
    chk("loop_class_held", class_o, 8'hFF);

    // Abort a walk in MAC1 with an asynchronous reset.
    start     = 1'b1;
    root_addr = 8'h40;
    feature   = 24'hFFFFFF;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_mac_en", mac_en, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_err", err, 1'b0);
    chk("mid_rst_node_addr", node_addr, 8'h00);
    chk("mid_rst_mac_en", mac_en, 1'b0);
    chk("mid_rst_mac_a", mac_a, 8'h00);
    chk("mid_rst_mac_b", mac_b, 8'h00);
    @(negedge clk);
    step();
    rst_n = 1'b1;
    step();
    run_walk("after_rst", 8'h10, 24'h030000, 8'h2A, 1'b0, 13, 0, acc_wait);
    step();

    run_walk("start_busy", 8'h10, 24'h030000, 8'h2A, 1'b0, 13, 3, acc_wait);
    run_walk("back2back", 8'h00, 24'h020202, 8'h05, 1'b0, 7, 0, acc_wait);
    chk("back2back_accept_edges", acc_wait, 2);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bdd_traverse_ctrl.md
# bdd_traverse_ctrl

Sequencer for the BDD/decision-tree accelerator datapath. It walks the tree from a root address to a class leaf. At each node it reads the coefficient word from the node SRAM and the child word from the child SRAM, drives the MAC through a three-term dot product against the latched feature vector, compares the result with the node threshold, and follows the selected child pointer. It sits between the host-facing start/done interface and the node SRAM, child SRAM and MAC instances.

## Interface
Parameters:
- ADDR_W, 8, node address width (both SRAMs share it).
- ACC_W, 18, MAC accumulator width (3 × 8b×8b unsigned products, no overflow).
- MAX_DEPTH, 32, node visits allowed before the walk aborts with an error.

Ports:
- clk, in, 1, single clock; all state changes on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, begin a walk; sampled only in IDLE.
- root_addr, in, ADDR_W, first node address; latched on accepted start.
- feature, in, 24, {f0,f1,f2} unsigned bytes; latched on accepted start.
- busy, out, 1, high from the cycle after accepted start until done.
- done, out, 1, one-cycle pulse at walk end.
- class_o, out, 8, leaf class; held until the next accepted start.
- err, out, 1, depth abort flag; valid with done, held like class_o.
- node_addr, out, ADDR_W, address to node and child SRAMs.
- sram_re, out, 1, read strobe; data is valid on the following edge.
- node_data, in, 32, {c1,c2,c3,thr}, bytes [31:24],[23:16],[15:8],[7:0].
- child_data, in, 18, {hi[8:0], lo[8:0]}; bit 8 of each field set = class leaf, bits [7:0] = class or next address.
- mac_clr, out, 1, synchronous clear of the MAC accumulator.
- mac_en, out, 1, accumulate mac_a×mac_b on this edge.
- mac_a, out, 8, coefficient operand.
- mac_b, out, 8, feature operand.
- mac_acc, in, ACC_W, accumulator value; reflects the previous edge's update.

## Operation
- States: IDLE, FETCH, WAIT, MAC0, MAC1, MAC2, DECIDE, FIN.
- IDLE + start: latch root_addr into cur_addr and feature into feat_r; clear the depth counter; go to FETCH.
- FETCH: node_addr=cur_addr, sram_re=1; go to WAIT.
- WAIT: register node_data and child_data into coef_r and child_r; assert mac_clr; go to MAC0.
- MAC0 / MAC1 / MAC2: mac_en=1 with (c1,f0) / (c2,f1) / (c3,f2) respectively.
- DECIDE: compare mac_acc with {0,thr}, unsigned. If mac_acc < thr, sel=child_r.hi; else sel=child_r.lo.
  - If sel[8]=1: class_o=sel[7:0], err=0, go to FIN.
  - Else if depth+1 = MAX_DEPTH: err=1, class_o=8'hFF, go to FIN.
  - Else: cur_addr=sel[7:0], depth+1, go to FETCH.
- FIN: done=1, busy=0, go to IDLE.
- start outside IDLE is ignored; it is not queued.
- mac_a, mac_b, mac_en and mac_clr are 0 in every state except where stated above.
- Reset, including during a walk: state=IDLE, busy=0, done=0, err=0, class_o=0, node_addr=0, sram_re=0, mac_clr=0, mac_en=0, mac_a=0, mac_b=0, depth=0.

## Timing
- Per internal node: 6 cycles (FETCH, WAIT, MAC0, MAC1, MAC2, DECIDE).
- Walk of N nodes: start edge to done pulse = 6N+1 cycles; done is followed by IDLE on the next cycle.
- A new start is accepted in the cycle after done (back-to-back walks supported).
- MAC contract: clear and accumulate take effect on the edge in which they are asserted. mac_acc in DECIDE equals c1·f0 + c2·f1 + c3·f2.
- Equality (acc = thr) selects lo.
- All outputs are registered; no combinational path from any input to any output.

## Structure
- Package bdd_pkg holds:
  - the state enum;
  - node word field offsets and child word field offsets;
  - the LEAF_BIT index (8);
  - the ERR_CLASS constant (8'hFF).
- One natural sub-module: bdd_depth_guard, a depth counter with terminal-count compare against MAX_DEPTH. The FSM and datapath registers stay in the top.

## Test plan
- Single-leaf root: root 0x00, node {1,1,1,0x10}, feature {2,2,2}, child hi=0x105 → acc=6<16, class_o=0x05, err=0, done 7 cycles after start.
- Two-level, lo path: root node {2,0,0,0x04}, feature {3,0,0}, acc=6 → lo=0x003. Node 3 has lo=0x12A → class 0x2A after 13 cycles.
- Threshold equality: acc=thr=0x20 → lo field taken.
- Loop detection: node 0 child hi=lo=0x000 → err=1, class_o=0xFF after MAX_DEPTH visits (193 cycles at default).
- Reset mid-walk: assert rst_n=0 in MAC1 → all outputs at reset values immediately. After release, a new start produces a correct walk.
- Start while busy: pulse start in MAC0 with a different root → ignored; the original walk completes unchanged. Back-to-back start the cycle after done is accepted.
